// File: rtl/errmon_pkg.sv
// Shared types for the two-rail error monitor sink.
// Holds the channel-state encoding, the out_src codes and the two-rail decode helper.
// Pure declarations: no latency, no backpressure.
package errmon_pkg;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_SUSPECT = 2'b01,
        ST_FAILED  = 2'b10
    } chan_state_e;

    localparam logic [1:0] SRC_X    = 2'b00;
    localparam logic [1:0] SRC_Y    = 2'b01;
    localparam logic [1:0] SRC_NONE = 2'b10;

    // A two-rail pair is a valid code word only when its rails differ;
    // 00 and 11 mean the checker upstream saw a fault.
    function automatic logic is_noncode(input logic [1:0] e);
        return (e[0] == e[1]);
    endfunction

endpackage

// File: rtl/errmon_two_rail_sink_if.sv
// Bundle of the upstream sample, downstream result and status signals of the sink.
// No logic; latency and backpressure are those of the attached sink.
// master = the environment (upstream + downstream), slave = errmon_two_rail_sink.
// Optional syn/syn_valid members exist only when ERRMON_SYNDROME_LOG_EN is defined.
interface errmon_two_rail_sink_if #(
    parameter int CNT_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       x_sum;
    logic [2:0]       y_sum;
    logic             x_cout;
    logic             y_cout;
    logic [1:0]       x_err;
    logic [1:0]       y_err;
    logic             clr_cnt;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_sum;
    logic             out_cout;
    logic [1:0]       out_src;
    logic             out_fatal;
    logic             out_disagree;
    logic [1:0]       x_state;
    logic [1:0]       y_state;
    logic [CNT_W-1:0] x_err_cnt;
    logic [CNT_W-1:0] y_err_cnt;
`ifdef ERRMON_SYNDROME_LOG_EN
    logic             syn_valid;
    logic [3:0]       syn;

    modport master (
        output in_valid, x_sum, y_sum, x_cout, y_cout, x_err, y_err, clr_cnt, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_src, out_fatal, out_disagree,
               x_state, y_state, x_err_cnt, y_err_cnt, syn_valid, syn
    );
    modport slave (
        input  in_valid, x_sum, y_sum, x_cout, y_cout, x_err, y_err, clr_cnt, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_src, out_fatal, out_disagree,
               x_state, y_state, x_err_cnt, y_err_cnt, syn_valid, syn
    );
`else
    modport master (
        output in_valid, x_sum, y_sum, x_cout, y_cout, x_err, y_err, clr_cnt, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_src, out_fatal, out_disagree,
               x_state, y_state, x_err_cnt, y_err_cnt
    );
    modport slave (
        input  in_valid, x_sum, y_sum, x_cout, y_cout, x_err, y_err, clr_cnt, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_src, out_fatal, out_disagree,
               x_state, y_state, x_err_cnt, y_err_cnt
    );
`endif
endinterface

// File: rtl/errmon_chan_fsm.sv
// Per-channel fault classifier (OK/SUSPECT/FAILED) plus saturating error counter.
// State and counter update on the accepting edge, visible the following cycle.
// No handshake of its own: it advances only when the parent asserts accept.
// Ports: clk, rst (sync, active high), accept, err, clr_cnt in; state, err_cnt out.
module errmon_chan_fsm
    import errmon_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter int FAIL_THRESH    = 4,
    parameter int RECOVER_THRESH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic             err,
    input  logic             clr_cnt,
    output chan_state_e      state,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [8:0] FAIL_T    = 9'(FAIL_THRESH);
    localparam logic [8:0] RECOVER_T = 9'(RECOVER_THRESH);

    chan_state_e      state_q, state_d;
    logic [7:0]       run_err_q, run_err_d;
    logic [7:0]       run_ok_q, run_ok_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       run_err_inc;
    logic [8:0]       run_ok_inc;

    // One bit of headroom so the threshold compare never sees a wrapped value.
    assign run_err_inc = {1'b0, run_err_q} + 9'd1;
    assign run_ok_inc  = {1'b0, run_ok_q} + 9'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_OK;
            run_err_q <= '0;
            run_ok_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            run_err_q <= run_err_d;
            run_ok_q  <= run_ok_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_err_d = run_err_q;
        run_ok_d  = run_ok_q;
        cnt_d     = cnt_q;
        if (accept) begin
            case (state_q)
                ST_OK: begin
                    if (err) begin
                        state_d   = ST_SUSPECT;
                        run_err_d = 8'd1;
                    end
                end
                ST_SUSPECT: begin
                    if (!err) begin
                        state_d   = ST_OK;
                        run_err_d = '0;
                    end else if (run_err_inc >= FAIL_T) begin
                        state_d   = ST_FAILED;
                        run_err_d = '0;
                        run_ok_d  = '0;
                    end else begin
                        run_err_d = run_err_inc[7:0];
                    end
                end
                ST_FAILED: begin
                    if (err) begin
                        run_ok_d = '0;
                    end else if (run_ok_inc >= RECOVER_T) begin
                        state_d  = ST_OK;
                        run_ok_d = '0;
                    end else begin
                        run_ok_d = run_ok_inc[7:0];
                    end
                end
                default: begin
                    state_d   = ST_OK;
                    run_err_d = '0;
                    run_ok_d  = '0;
                end
            endcase
            if (err && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Clear wins over a same-cycle increment.
        if (clr_cnt) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        state   = state_q;
        err_cnt = cnt_q;
    end

endmodule

// File: rtl/errmon_two_rail_sink.sv
// Registers X/Y adder results, picks a trustworthy one and tracks per-channel faults.
// Latency 1 cycle through a single output register; full throughput with out_ready high.
// Stalls (in_ready low, outputs frozen) while the output register is held by !out_ready.
// Ports: clk, rst (sync, active high); bus = errmon_two_rail_sink_if.slave.
// Macro ERRMON_SYNDROME_LOG_EN adds a first-error syndrome capture (syn, syn_valid).
module errmon_two_rail_sink
    import errmon_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter int FAIL_THRESH    = 4,
    parameter int RECOVER_THRESH = 16
) (
    input logic                   clk,
    input logic                   rst,
    errmon_two_rail_sink_if.slave bus
);

    logic        accept;
    logic        in_ready;
    logic        x_bad, y_bad;
    logic        x_use, y_use;
    logic        disagree;
    logic        fsm_accept;
    chan_state_e x_state, y_state;

    logic       out_valid_q, out_valid_d;
    logic [2:0] out_sum_q, out_sum_d;
    logic       out_cout_q, out_cout_d;
    logic [1:0] out_src_q, out_src_d;
    logic       out_fatal_q, out_fatal_d;
    logic       out_dis_q, out_dis_d;

    assign in_ready = !rst && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    assign x_bad = is_noncode(bus.x_err);
    assign y_bad = is_noncode(bus.y_err);

    // Selection looks at the state registered before this edge, so a channel
    // that fails on this sample is only excluded from the next one on.
    assign x_use = !x_bad && (x_state != ST_FAILED);
    assign y_use = !y_bad && (y_state != ST_FAILED);

    assign disagree = !x_bad && !y_bad &&
                      ({bus.x_cout, bus.x_sum} != {bus.y_cout, bus.y_sum});

    // A disagreeing pair carries no evidence about which channel is faulty,
    // so it leaves both classifiers untouched.
    assign fsm_accept = accept && !disagree;

    errmon_chan_fsm #(
        .CNT_W         (CNT_W),
        .FAIL_THRESH   (FAIL_THRESH),
        .RECOVER_THRESH(RECOVER_THRESH)
    ) u_x_fsm (
        .clk    (clk),
        .rst    (rst),
        .accept (fsm_accept),
        .err    (x_bad),
        .clr_cnt(bus.clr_cnt),
        .state  (x_state),
        .err_cnt(bus.x_err_cnt)
    );

    errmon_chan_fsm #(
        .CNT_W         (CNT_W),
        .FAIL_THRESH   (FAIL_THRESH),
        .RECOVER_THRESH(RECOVER_THRESH)
    ) u_y_fsm (
        .clk    (clk),
        .rst    (rst),
        .accept (fsm_accept),
        .err    (y_bad),
        .clr_cnt(bus.clr_cnt),
        .state  (y_state),
        .err_cnt(bus.y_err_cnt)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_cout_d  = out_cout_q;
        out_src_d   = out_src_q;
        out_fatal_d = out_fatal_q;
        out_dis_d   = out_dis_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_dis_d   = disagree;
            if (x_use) begin
                out_sum_d   = bus.x_sum;
                out_cout_d  = bus.x_cout;
                out_src_d   = SRC_X;
                out_fatal_d = 1'b0;
            end else if (y_use) begin
                out_sum_d   = bus.y_sum;
                out_cout_d  = bus.y_cout;
                out_src_d   = SRC_Y;
                out_fatal_d = 1'b0;
            end else begin
                out_sum_d   = '0;
                out_cout_d  = 1'b0;
                out_src_d   = SRC_NONE;
                out_fatal_d = 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_src_q   <= SRC_X;
            out_fatal_q <= 1'b0;
            out_dis_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
            out_src_q   <= out_src_d;
            out_fatal_q <= out_fatal_d;
            out_dis_q   <= out_dis_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_sum      = out_sum_q;
    assign bus.out_cout     = out_cout_q;
    assign bus.out_src      = out_src_q;
    assign bus.out_fatal    = out_fatal_q;
    assign bus.out_disagree = out_dis_q;
    assign bus.x_state      = x_state;
    assign bus.y_state      = y_state;

`ifdef ERRMON_SYNDROME_LOG_EN
    logic       syn_valid_q, syn_valid_d;
    logic [3:0] syn_q, syn_d;

    // Only the first faulty sample is kept; later ones are ignored until cleared.
    always_comb begin
        syn_valid_d = syn_valid_q;
        syn_d       = syn_q;
        if (bus.clr_cnt) begin
            syn_valid_d = 1'b0;
            syn_d       = '0;
        end else if (accept && (x_bad || y_bad) && !syn_valid_q) begin
            syn_valid_d = 1'b1;
            syn_d       = {bus.y_err, bus.x_err};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            syn_valid_q <= 1'b0;
            syn_q       <= '0;
        end else begin
            syn_valid_q <= syn_valid_d;
            syn_q       <= syn_d;
        end
    end

    assign bus.syn_valid = syn_valid_q;
    assign bus.syn       = syn_q;
`endif

endmodule

// File: tb/tb_errmon_two_rail_sink.sv
module tb_errmon_two_rail_sink;

    logic clk;
    logic rst;

    errmon_two_rail_sink_if #(.CNT_W(8)) bus ();

    errmon_two_rail_sink #(
        .CNT_W         (8),
        .FAIL_THRESH   (4),
        .RECOVER_THRESH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       xc; logic [2:0] xs; logic [1:0] xe;
        logic       yc; logic [2:0] ys; logic [1:0] ye;
        logic       clr;
        logic       e_cout; logic [2:0] e_sum; logic [1:0] e_src;
        logic       e_fatal; logic e_dis;
        logic [1:0] e_xst; logic [1:0] e_yst;
        logic [7:0] e_xcnt; logic [7:0] e_ycnt;
    } vec_t;

    typedef struct {
        logic [2:0] sum; logic cout; logic [1:0] src; logic fatal; logic dis;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[10];

    function automatic vec_t mk(input logic xc, input logic [2:0] xs, input logic [1:0] xe,
                                input logic yc, input logic [2:0] ys, input logic [1:0] ye,
                                input logic clr,
                                input logic ec, input logic [2:0] es, input logic [1:0] esrc,
                                input logic ef, input logic ed,
                                input logic [1:0] xst, input logic [1:0] yst,
                                input logic [7:0] xcnt, input logic [7:0] ycnt);
        vec_t v;
        v.xc = xc; v.xs = xs; v.xe = xe; v.yc = yc; v.ys = ys; v.ye = ye; v.clr = clr;
        v.e_cout = ec; v.e_sum = es; v.e_src = esrc; v.e_fatal = ef; v.e_dis = ed;
        v.e_xst = xst; v.e_yst = yst; v.e_xcnt = xcnt; v.e_ycnt = ycnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.x_cout = v.xc; bus.x_sum = v.xs; bus.x_err = v.xe;
        bus.y_cout = v.yc; bus.y_sum = v.ys; bus.y_err = v.ye;
        bus.clr_cnt = v.clr;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input vec_t v, input string tag);
        exp_t e;
        int   budget;
        drive(v);
        bus.in_valid = 1'b1;
        budget = 0;
        @(negedge clk);
        while (!bus.in_ready && budget < 50) begin
            budget++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s accept_timeout actual=in_ready0 required=in_ready1", tag);
        end else begin
            e.sum = v.e_sum; e.cout = v.e_cout; e.src = v.e_src;
            e.fatal = v.e_fatal; e.dis = v.e_dis;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.clr_cnt  = 1'b0;
        chk({tag, ".x_state"}, 32'(bus.x_state), 32'(v.e_xst));
        chk({tag, ".y_state"}, 32'(bus.y_state), 32'(v.e_yst));
        chk({tag, ".x_err_cnt"}, 32'(bus.x_err_cnt), 32'(v.e_xcnt));
        chk({tag, ".y_err_cnt"}, 32'(bus.y_err_cnt), 32'(v.e_ycnt));
    endtask

    // Scoreboard: a transfer completes on the next posedge when valid&&ready at negedge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=sum%0h src%0h required=no_output",
                         bus.out_sum, bus.out_src);
            end else begin
                e = sbq.pop_front();
                chk("sb.out_sum", 32'(bus.out_sum), 32'(e.sum));
                chk("sb.out_cout", 32'(bus.out_cout), 32'(e.cout));
                chk("sb.out_src", 32'(bus.out_src), 32'(e.src));
                chk("sb.out_fatal", 32'(bus.out_fatal), 32'(e.fatal));
                chk("sb.out_disagree", 32'(bus.out_disagree), 32'(e.dis));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // X/Y adder samples with expected selection and post-edge FSM/counter values.
        tbl[0] = mk(0,3'b101,2'b01, 0,3'b101,2'b10, 0, 0,3'b101,2'b00,0,0, 2'd0,2'd0,8'd0,8'd0);
        tbl[1] = mk(1,3'b111,2'b00, 0,3'b000,2'b11, 0, 0,3'b000,2'b10,1,0, 2'd1,2'd1,8'd1,8'd1);
        tbl[2] = mk(0,3'b001,2'b10, 0,3'b010,2'b01, 0, 0,3'b001,2'b00,0,1, 2'd1,2'd1,8'd1,8'd1);
        tbl[3] = mk(1,3'b100,2'b01, 1,3'b100,2'b01, 0, 1,3'b100,2'b00,0,0, 2'd0,2'd0,8'd1,8'd1);
        tbl[4] = mk(0,3'b011,2'b11, 1,3'b010,2'b01, 0, 1,3'b010,2'b01,0,0, 2'd1,2'd0,8'd2,8'd1);
        tbl[5] = mk(0,3'b011,2'b11, 1,3'b010,2'b01, 0, 1,3'b010,2'b01,0,0, 2'd1,2'd0,8'd3,8'd1);
        tbl[6] = mk(0,3'b011,2'b11, 1,3'b010,2'b01, 0, 1,3'b010,2'b01,0,0, 2'd1,2'd0,8'd4,8'd1);
        tbl[7] = mk(0,3'b011,2'b11, 1,3'b010,2'b01, 0, 1,3'b010,2'b01,0,0, 2'd2,2'd0,8'd5,8'd1);
        tbl[8] = mk(1,3'b010,2'b10, 1,3'b010,2'b01, 0, 1,3'b010,2'b01,0,0, 2'd2,2'd0,8'd5,8'd1);
        tbl[9] = mk(0,3'b011,2'b00, 1,3'b010,2'b10, 0, 1,3'b010,2'b01,0,0, 2'd2,2'd0,8'd6,8'd1);

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.clr_cnt = 1'b0;
        bus.x_sum = '0; bus.y_sum = '0; bus.x_cout = 1'b0; bus.y_cout = 1'b0;
        bus.x_err = 2'b01; bus.y_err = 2'b01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.out_sum", 32'(bus.out_sum), 32'd0);
        chk("rst.out_cout", 32'(bus.out_cout), 32'd0);
        chk("rst.out_src", 32'(bus.out_src), 32'd0);
        chk("rst.out_fatal", 32'(bus.out_fatal), 32'd0);
        chk("rst.out_disagree", 32'(bus.out_disagree), 32'd0);
        chk("rst.x_state", 32'(bus.x_state), 32'd0);
        chk("rst.y_state", 32'(bus.y_state), 32'd0);
        chk("rst.x_err_cnt", 32'(bus.x_err_cnt), 32'd0);
        chk("rst.y_err_cnt", 32'(bus.y_err_cnt), 32'd0);
        chk("rst.in_ready_after", 32'(bus.in_ready), 32'd1);
`ifdef ERRMON_SYNDROME_LOG_EN
        chk("rst.syn_valid", 32'(bus.syn_valid), 32'd0);
`endif
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            send(tbl[i], $sformatf("tbl%0d", i));
`ifdef ERRMON_SYNDROME_LOG_EN
            if (i == 0) chk("syn.valid_t0", 32'(bus.syn_valid), 32'd0);
            if (i >= 1) begin
                chk("syn.valid_first", 32'(bus.syn_valid), 32'd1);
                chk("syn.first", 32'(bus.syn), 32'hC);
            end
`endif
        end

        // Recovery from FAILED: 9 clean, one error restarting the run, 16 clean, then X again.
        for (int k = 1; k <= 9; k++)
            send(mk(0,3'b110,2'b01, 0,3'b110,2'b10, 0, 0,3'b110,2'b01,0,0,
                    2'd2,2'd0,8'd6,8'd1), $sformatf("rec_a%0d", k));
        send(mk(0,3'b110,2'b11, 0,3'b110,2'b10, 0, 0,3'b110,2'b01,0,0,
                2'd2,2'd0,8'd7,8'd1), "rec_err");
        for (int k = 1; k <= 16; k++)
            send(mk(0,3'b110,2'b01, 0,3'b110,2'b10, 0, 0,3'b110,2'b01,0,0,
                    (k == 16) ? 2'd0 : 2'd2, 2'd0, 8'd7, 8'd1), $sformatf("rec_b%0d", k));
        send(mk(0,3'b110,2'b01, 0,3'b110,2'b10, 0, 0,3'b110,2'b00,0,0,
                2'd0,2'd0,8'd7,8'd1), "rec_17");

        // Backpressure: hold the output for 3 cycles with a pending sample.
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(mk(0,3'b001,2'b01, 0,3'b001,2'b01, 0, 0,3'b001,2'b00,0,0,
                2'd0,2'd0,8'd7,8'd1), "bp_a");
        v = mk(1,3'b010,2'b10, 1,3'b010,2'b10, 0, 1,3'b010,2'b00,0,0, 2'd0,2'd0,8'd7,8'd1);
        drive(v);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp.out_sum", 32'(bus.out_sum), 32'd1);
            chk("bp.out_src", 32'(bus.out_src), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(v, "bp_b");
        send(mk(0,3'b111,2'b01, 0,3'b111,2'b01, 0, 0,3'b111,2'b00,0,0,
                2'd0,2'd0,8'd7,8'd1), "bp_c");

        // clr_cnt coincident with an X error: counter ends at 0, FSM still moves.
        send(mk(0,3'b011,2'b11, 0,3'b100,2'b01, 1, 0,3'b100,2'b01,0,0,
                2'd1,2'd0,8'd0,8'd0), "clr_err");
`ifdef ERRMON_SYNDROME_LOG_EN
        chk("syn.clr_valid", 32'(bus.syn_valid), 32'd0);
`endif
        send(mk(0,3'b011,2'b11, 0,3'b100,2'b01, 0, 0,3'b100,2'b01,0,0,
                2'd1,2'd0,8'd1,8'd0), "syn_s1");
`ifdef ERRMON_SYNDROME_LOG_EN
        chk("syn.s1_valid", 32'(bus.syn_valid), 32'd1);
        chk("syn.s1", 32'(bus.syn), 32'h7);
`endif
        send(mk(0,3'b101,2'b01, 0,3'b110,2'b00, 0, 0,3'b101,2'b00,0,0,
                2'd0,2'd1,8'd1,8'd1), "syn_s2");
`ifdef ERRMON_SYNDROME_LOG_EN
        chk("syn.s2_valid", 32'(bus.syn_valid), 32'd1);
        chk("syn.s2", 32'(bus.syn), 32'h7);
`endif
        bus.clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_cnt = 1'b0;
        chk("clr.x_err_cnt", 32'(bus.x_err_cnt), 32'd0);
        chk("clr.y_err_cnt", 32'(bus.y_err_cnt), 32'd0);
        chk("clr.y_state_kept", 32'(bus.y_state), 32'd1);
`ifdef ERRMON_SYNDROME_LOG_EN
        chk("syn.clr_pulse_valid", 32'(bus.syn_valid), 32'd0);
        chk("syn.clr_pulse", 32'(bus.syn), 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("sb.drained", 32'(sbq.size()), 32'd0);

        // Reset while a sample is held discards it.
        bus.out_ready = 1'b0;
        send(mk(0,3'b001,2'b01, 0,3'b001,2'b01, 0, 0,3'b001,2'b00,0,0,
                2'd0,2'd0,8'd0,8'd0), "rst_mid");
        chk("rst_mid.held", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid.in_ready", 32'(bus.in_ready), 32'd0);
        sbq.delete();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid.out_valid_after", 32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/errmon_two_rail_sink.md
# errmon_two_rail_sink

Sequential consumer directly downstream of the dual-path (X/Y) fault-tolerant 3-bit adder. It registers both result paths each sample and decodes their two-rail error pairs (XE0/XE1, YE0/YE1). It selects a trustworthy result, runs a per-channel fault-classification FSM, and keeps saturating error statistics. Results are handed downstream over a valid/ready interface with a one-stage output register.

## Interface
Parameters:
- CNT_W, 8, width of per-channel error counters (saturating)
- FAIL_THRESH, 4, consecutive erroneous samples that move SUSPECT to FAILED; legal range 2..255
- RECOVER_THRESH, 16, consecutive clean samples that move FAILED to OK; legal range 1..255

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream sample valid
- in_ready  out  1  block can accept a sample
- x_sum / y_sum  in  3  X / Y path sum
- x_cout / y_cout  in  1  X / Y path carry
- x_err / y_err  in  2  {E1,E0} two-rail error pair of each path
- clr_cnt  in  1  synchronous clear of statistics
- out_valid  out  1  output register holds a sample
- out_ready  in  1  downstream accepts
- out_sum  out  3  selected sum
- out_cout  out  1  selected carry
- out_src  out  2  00 = X, 01 = Y, 10 = none
- out_fatal  out  1  no usable channel for this sample
- out_disagree  out  1  both channels code-clean but {cout,sum} differ
- x_state / y_state  out  2  channel FSM state
- x_err_cnt / y_err_cnt  out  CNT_W  total erroneous samples per channel

## Operation
- Accept on in_valid && in_ready. in_ready = !rst && (!out_valid || out_ready).
- Channel error: e0 == e1, i.e. the pair is a non-code word (00 or 11). The code words 01 and 10 are clean.
- Selection uses the FSM state registered before the accepting edge:
  - X is used if X is clean and x_state != FAILED.
  - Otherwise Y is used if Y is clean and y_state != FAILED.
  - Otherwise out_src = 10, out_fatal = 1, out_sum = 0, out_cout = 0.
- out_disagree = 1 when both channels are clean and {cout,sum} differ. The X value is still forwarded, and no counters or FSMs change.
- FSM per channel, with states OK = 00, SUSPECT = 01, FAILED = 10. It advances only on accepted samples.
  - OK: error goes to SUSPECT with run_err = 1. Clean stays OK.
  - SUSPECT: error increments run_err; when run_err reaches FAIL_THRESH, go to FAILED. Clean goes to OK with run_err = 0.
  - FAILED: clean increments run_ok; when run_ok reaches RECOVER_THRESH, go to OK with run_ok = 0. Error resets run_ok to 0.
- Error counters increment on each accepted erroneous sample and saturate at all-ones (no wrap).
- clr_cnt clears x_err_cnt and y_err_cnt, and has priority over a simultaneous increment (counter becomes 0). It does not touch the FSMs.
- Reset values: out_valid 0, out_sum 0, out_cout 0, out_src 00, out_fatal 0, out_disagree 0, states OK, counters 0, run counters 0. in_ready is 0 while rst is high.
- Reset asserted mid-transfer discards the held output sample.

## Timing
- Latency 1: a sample accepted at edge N appears on the out_* ports after edge N, with out_valid = 1.
- Throughput is 1 sample/cycle when out_ready is held high. Simultaneous accept and drain is allowed.
- While out_valid && !out_ready, all out_* ports are held stable and in_ready = 0.
- FSM state and counters update on the same edge as acceptance, and are visible on x_state/y_state the following cycle.
- A channel entering FAILED on edge N is excluded from selection for samples accepted at edge N+1 onward.

## Configuration
- Macro ERRMON_SYNDROME_LOG_EN.
- Defined:
  - Adds the ports syn_valid out 1 and syn out 4 = {y_err, x_err}.
  - These capture the first accepted sample with any channel error after reset or clr_cnt.
  - The capture is held (later errors ignored) until rst or clr_cnt clears both to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

## Structure
- Package errmon_pkg holds:
  - the channel-state enum (OK, SUSPECT, FAILED)
  - the out_src encodings
  - the two-rail "non-code" helper function
- Sub-module errmon_chan_fsm, instantiated once per channel. It holds the FSM, run_err/run_ok and the saturating counter. Inputs: accept, err, clr_cnt. Outputs: state, err_cnt.
- The top level holds selection, the output register and the handshake.

## Test plan
- Reset, then accept X = {0,101} err 01 and Y = {0,101} err 10 → out_src 00, out_sum 101, out_fatal 0, both states OK, counters 0.
- Four consecutive samples with x_err = 11, y_err = 01, Y = {1,010} → x_state goes OK→SUSPECT→SUSPECT→SUSPECT→FAILED, x_err_cnt = 4, all outputs sourced from Y. A fifth sample with X clean still gives out_src 01.
- From FAILED, 16 clean X samples → x_state returns to OK after the 16th. The 17th output has out_src 00. One error inserted at sample 10 restarts the count.
- Both channels erroneous (x_err = 00, y_err = 11) → out_src 10, out_fatal 1, out_sum 000, out_cout 0. Both counters increment.
- Hold out_ready = 0 for 3 cycles with in_valid = 1 → out_* stay stable, in_ready = 0, nothing is accepted. Releasing gives back-to-back transfers with no loss. clr_cnt coincident with an error leaves the counter at 0.
- With ERRMON_SYNDROME_LOG_EN defined, inject x_err = 11 then y_err = 00 → syn = {01,11}, syn_valid 1, unchanged by the second error. clr_cnt clears syn_valid.
